hiscore_upload: RTL and testbench

Upload-side responder for the HPS ioctl channel. It serves bytes from a window of core work RAM, such as the high-score table, when the HPS reads a file out of the core. This is the reverse of the ROM download path. It sits in the emu top level between hps_io (ioctl_upload/ioctl_rd/ioctl_din/ioctl_wait) and a shared read port on the core RAM, which it only uses when the core grants access.

---
 rtl/hiscore_upload.sv | 133 +++++++++++++
 tb/tb_hiscore_upload.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hiscore_upload.sv
// Upload-side ioctl responder: serves bytes from a window of core RAM to the HPS,
// borrowing the shared RAM read port only while the core grants it.
`timescale 1ns/1ps
module hiscore_upload #(
  parameter logic [7:0]  INDEX = 8'd4,
  parameter logic [15:0] BASE  = 16'h0000,
  parameter logic [15:0] SIZE  = 16'd64,
  parameter logic [7:0]  FILL  = 8'h00
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_upload,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_rd,
  input  logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic        ram_req,
  input  logic        ram_gnt,
  output logic [15:0] ram_addr,
  output logic        ram_rd,
  input  logic [7:0]  ram_q,
  output logic        busy,
  output logic [7:0]  sum,
  output logic        done
);

  typedef enum logic [1:0] {StIdle, StReq, StRd, StCap} state_e;

  state_e      state_q, state_d;
  logic [7:0]  din_q, din_d;
  logic        wait_q, wait_d;
  logic        req_q, req_d;
  logic        rd_q, rd_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  sum_q, sum_d;
  logic        busy_q;
  logic        done_q;

  logic active;
  logic in_window;

  assign active    = ioctl_upload && (ioctl_index == INDEX);
  assign in_window = ioctl_addr < {9'd0, SIZE};

  always_comb begin
    state_d = state_q;
    din_d   = din_q;
    wait_d  = wait_q;
    req_d   = req_q;
    rd_d    = 1'b0;
    addr_d  = addr_q;
    sum_d   = sum_q;

    if (active && !busy_q) begin
      sum_d = 8'h00;
    end

    // Losing the upload wins over everything: drop the port and return to idle.
    if (!active) begin
      state_d = StIdle;
      wait_d  = 1'b0;
      req_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ioctl_rd) begin
            if (in_window) begin
              addr_d  = BASE + ioctl_addr[15:0];
              wait_d  = 1'b1;
              req_d   = 1'b1;
              state_d = StReq;
            end else begin
              din_d = FILL;
            end
          end
        end
        StReq: begin
          if (ram_gnt) begin
            rd_d    = 1'b1;
            state_d = StRd;
          end
        end
        // A grant lost during the read cycle invalidates ram_q; retry from REQ.
        StRd: begin
          state_d = ram_gnt ? StCap : StReq;
        end
        StCap: begin
          din_d   = ram_q;
          sum_d   = sum_q + ram_q;
          wait_d  = 1'b0;
          req_d   = 1'b0;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      din_q   <= 8'h00;
      wait_q  <= 1'b0;
      req_q   <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= 16'h0000;
      sum_q   <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      wait_q  <= wait_d;
      req_q   <= req_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      sum_q   <= sum_d;
      busy_q  <= active;
      done_q  <= busy_q && !active;
    end
  end

  assign ioctl_din  = din_q;
  assign ioctl_wait = wait_q;
  assign ram_req    = req_q;
  assign ram_rd     = rd_q;
  assign ram_addr   = addr_q;
  assign busy       = busy_q;
  assign sum        = sum_q;
  assign done       = done_q;

endmodule

// File: tb/tb_hiscore_upload.sv
// Bench for hiscore_upload: directed and randomized uploads against a transaction-level
// model that derives each read's timing from the planned grant trace.
`timescale 1ns/1ps
module tb_hiscore_upload;

  localparam logic [7:0]  INDEX = 8'd4;
  localparam logic [15:0] BASE  = 16'h0100;
  localparam logic [15:0] SIZE  = 16'd4;
  localparam logic [7:0]  FILL  = 8'hE7;

  logic        clk_sys;
  logic        reset_n;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        ram_req;
  logic        ram_gnt;
  logic [15:0] ram_addr;
  logic        ram_rd;
  logic [7:0]  ram_q;
  logic        busy;
  logic [7:0]  sum;
  logic        done;

  hiscore_upload #(
    .INDEX(INDEX),
    .BASE (BASE),
    .SIZE (SIZE),
    .FILL (FILL)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .ioctl_upload(ioctl_upload),
    .ioctl_index (ioctl_index),
    .ioctl_rd    (ioctl_rd),
    .ioctl_addr  (ioctl_addr),
    .ioctl_din   (ioctl_din),
    .ioctl_wait  (ioctl_wait),
    .ram_req     (ram_req),
    .ram_gnt     (ram_gnt),
    .ram_addr    (ram_addr),
    .ram_rd      (ram_rd),
    .ram_q       (ram_q),
    .busy        (busy),
    .sum         (sum),
    .done        (done)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Core RAM: data one cycle after ram_rd, garbage otherwise so late captures show up.
  logic [7:0] mem [0:65535];
  always @(posedge clk_sys) begin
    if (ram_rd) ram_q <= mem[ram_addr];
    else        ram_q <= 8'($urandom);
  end

  int n_chk  = 0;
  int n_pass = 0;

  // Expected outputs for the current cycle.
  logic        e_wait = 1'b0;
  logic        e_req  = 1'b0;
  logic        e_rd   = 1'b0;
  logic [15:0] e_addr = 16'h0000;
  logic [7:0]  e_din  = 8'h00;
  logic [7:0]  e_sum  = 8'h00;
  logic        e_busy = 1'b0;
  logic        e_done = 1'b0;
  bit          act_prev = 1'b0;

  int rd_seen, wait_seen, done_seen, req_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  always @(negedge clk_sys) begin
    chk("ioctl_wait", 32'(ioctl_wait), 32'(e_wait));
    chk("ram_req", 32'(ram_req), 32'(e_req));
    chk("ram_rd", 32'(ram_rd), 32'(e_rd));
    chk("ioctl_din", 32'(ioctl_din), 32'(e_din));
    chk("sum", 32'(sum), 32'(e_sum));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    if (e_req) chk("ram_addr", 32'(ram_addr), 32'(e_addr));
    rd_seen   += int'(ram_rd);
    wait_seen += int'(ioctl_wait);
    done_seen += int'(done);
    req_seen  += int'(ram_req);
  end

  // Advance one cycle: update the upload-level expectations, then drive inputs.
  task automatic step(input bit up, input logic [7:0] idx, input bit rd,
                      input logic [24:0] addr, input bit gnt);
    @(posedge clk_sys);
    #1;
    e_done = e_busy && !act_prev;
    if (act_prev && !e_busy) e_sum = 8'h00;
    e_busy = act_prev;
    e_rd   = 1'b0;
    ioctl_upload = up;
    ioctl_index  = idx;
    ioctl_rd     = rd;
    ioctl_addr   = addr;
    ram_gnt      = gnt;
    act_prev     = up && (idx == INDEX);
  endtask

  // One HPS read; the grant trace is planned up front and the read's timeline derived
  // from it: a grant seen in REQ strobes ram_rd, which needs the grant again next cycle.
  task automatic run_read(input logic [24:0] addr, input int delay, input bit drop_rd,
                          input bit rnd, input int abort_in, output bit aborted);
    bit          g [0:79];
    int          att[$];
    int          c, k, last, abort_at;
    bit          inwin, hit;
    logic [15:0] ra;
    inwin = addr < {9'd0, SIZE};
    ra    = BASE + addr[15:0];
    for (int i = 0; i < 80; i++) g[i] = rnd ? ($urandom_range(0, 4) < 3) : (i > delay);
    if (drop_rd) g[delay + 2] = 1'b0;
    for (int i = 60; i < 80; i++) g[i] = 1'b1;
    c = 0;
    k = 1;
    while (c == 0) begin
      if (g[k]) begin
        att.push_back(k);
        if (g[k + 1]) c = k + 3;
        else k += 2;
      end else begin
        k++;
      end
    end
    abort_at = (inwin && abort_in > 0 && abort_in < c) ? abort_in : 0;
    aborted  = abort_at != 0;
    last     = !inwin ? 1 : (aborted ? abort_at + 1 : c);
    for (int j = 0; j <= last; j++) begin
      step(!(aborted && j >= abort_at), INDEX, j == 0, (j == 0) ? addr : 25'($urandom), g[j]);
      if (j > 0) begin
        if (!inwin) begin
          e_din = FILL;
        end else if (aborted && j == abort_at + 1) begin
          e_wait = 1'b0;
          e_req  = 1'b0;
        end else if (j == c) begin
          e_wait = 1'b0;
          e_req  = 1'b0;
          e_din  = mem[ra];
          e_sum  = e_sum + mem[ra];
        end else begin
          e_wait = 1'b1;
          e_req  = 1'b1;
          e_addr = ra;
          hit    = 1'b0;
          foreach (att[i]) if (att[i] == j - 1) hit = 1'b1;
          e_rd = hit;
        end
      end
    end
  endtask

  task automatic clear_seen();
    rd_seen   = 0;
    wait_seen = 0;
    done_seen = 0;
    req_seen  = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    bit          ab;
    int          nrd, abort_in;
    logic [24:0] a;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0100] = 8'h11;
    mem[16'h0101] = 8'h22;
    mem[16'h0102] = 8'h33;
    mem[16'h0103] = 8'h44;

    reset_n      = 1'b0;
    ioctl_upload = 1'b0;
    ioctl_index  = 8'h00;
    ioctl_rd     = 1'b0;
    ioctl_addr   = 25'd0;
    ram_gnt      = 1'b0;
    clear_seen();
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_din", 32'(ioctl_din), 32'h0);
    chk("rst_wait", 32'(ioctl_wait), 32'h0);
    chk("rst_req", 32'(ram_req), 32'h0);
    chk("rst_rd", 32'(ram_rd), 32'h0);
    chk("rst_addr", 32'(ram_addr), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_sum", 32'(sum), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    reset_n = 1'b1;

    // Window read with grant tied high.
    repeat (2) step(1, INDEX, 0, 25'd0, 1);
    clear_seen();
    for (int i = 0; i < 4; i++) begin
      run_read(25'(i), 0, 0, 0, 0, ab);
      if (i == 0) chk("lat_gnt_high", 32'(wait_seen + 1), 32'd4);
    end
    chk("din_44", 32'(ioctl_din), 32'h44);
    chk("sum_aa", 32'(sum), 32'hAA);
    clear_seen();
    repeat (3) step(0, INDEX, 0, 25'd0, 1);
    chk("done_once", 32'(done_seen), 32'd1);
    chk("sum_held", 32'(sum), 32'hAA);

    // Delayed grant, then grant lost during the read cycle.
    repeat (2) step(1, INDEX, 0, 25'd0, 0);
    clear_seen();
    run_read(25'd2, 10, 0, 0, 0, ab);
    chk("lat_delay10", 32'(wait_seen + 1), 32'd14);
    chk("rd_once", 32'(rd_seen), 32'd1);
    chk("din_33", 32'(ioctl_din), 32'h33);
    clear_seen();
    run_read(25'd1, 0, 1, 0, 0, ab);
    chk("rd_twice", 32'(rd_seen), 32'd2);
    chk("lat_drop", 32'(wait_seen + 1), 32'd6);
    chk("din_22", 32'(ioctl_din), 32'h22);
    chk("sum_55", 32'(sum), 32'h55);

    // Out of range: FILL next cycle, no wait, sum untouched.
    clear_seen();
    run_read(25'd9, 0, 0, 0, 0, ab);
    chk("din_fill", 32'(ioctl_din), 32'(FILL));
    chk("oor_wait", 32'(wait_seen), 32'd0);
    chk("oor_sum", 32'(sum), 32'h55);
    step(1, INDEX, 0, 25'd0, 1);
    run_read(25'h010000, 0, 0, 0, 0, ab);

    // Abort while waiting for grant in REQ.
    step(1, INDEX, 0, 25'd0, 0);
    clear_seen();
    run_read(25'd0, 5, 0, 0, 3, ab);
    step(0, INDEX, 0, 25'd0, 0);
    chk("abort_done", 32'(done_seen), 32'd1);
    chk("abort_rd", 32'(rd_seen), 32'd0);
    chk("abort_sum", 32'(sum), 32'h55);

    // Wrong index: reads are ignored entirely.
    clear_seen();
    for (int i = 0; i < 8; i++) step(1, 8'h00, i[0], 25'(i & 3), 1);
    repeat (2) step(0, 8'h00, 0, 25'd0, 1);
    chk("widx_req", 32'(req_seen), 32'd0);
    chk("widx_done", 32'(done_seen), 32'd0);

    // Randomized uploads with random grant traces and occasional aborts.
    for (int u = 0; u < 25; u++) begin
      repeat (1 + $urandom_range(0, 2)) step(1, INDEX, 0, 25'($urandom), 1'($urandom));
      nrd = 2 + int'($urandom_range(0, 5));
      ab  = 1'b0;
      for (int r = 0; r < nrd && !ab; r++) begin
        if ($urandom_range(0, 9) < 7) a = 25'($urandom_range(0, 3));
        else if ($urandom_range(0, 1) == 0) a = 25'($urandom_range(4, 40));
        else a = 25'($urandom);
        abort_in = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 6)) : 0;
        run_read(a, 0, 0, 1, abort_in, ab);
        if (!ab) repeat ($urandom_range(0, 2)) step(1, INDEX, 0, 25'($urandom), 1'($urandom));
      end
      repeat (3) step(0, INDEX, 0, 25'd0, 1'($urandom));
    end

    // Asynchronous reset in the middle of a RAM read.
    repeat (2) step(1, INDEX, 0, 25'd0, 1);
    step(1, INDEX, 1, 25'd3, 1);
    step(1, INDEX, 0, 25'd0, 1);
    e_wait = 1'b1;
    e_req  = 1'b1;
    e_addr = BASE + 16'd3;
    step(1, INDEX, 0, 25'd0, 1);
    e_rd = 1'b1;
    #1;
    reset_n      = 1'b0;
    ioctl_upload = 1'b0;
    #1;
    chk("arst_din", 32'(ioctl_din), 32'h0);
    chk("arst_wait", 32'(ioctl_wait), 32'h0);
    chk("arst_req", 32'(ram_req), 32'h0);
    chk("arst_rd", 32'(ram_rd), 32'h0);
    chk("arst_addr", 32'(ram_addr), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_sum", 32'(sum), 32'h0);
    chk("arst_done", 32'(done), 32'h0);
    e_wait   = 1'b0;
    e_req    = 1'b0;
    e_rd     = 1'b0;
    e_din    = 8'h00;
    e_sum    = 8'h00;
    e_busy   = 1'b0;
    e_done   = 1'b0;
    act_prev = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    step(0, INDEX, 0, 25'd0, 1);
    repeat (2) step(1, INDEX, 0, 25'd0, 1);
    run_read(25'd0, 0, 0, 0, 0, ab);
    chk("post_rst_din", 32'(ioctl_din), 32'h11);
    chk("post_rst_sum", 32'(sum), 32'h11);
    repeat (3) step(0, INDEX, 0, 25'd0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
